// File: rtl/tag_allocator_fa_pkg.sv
// Shared definitions for the fully-associative tag table allocator: FSM states
// and the constant log2 helper used to derive index and offset widths.
package tag_allocator_fa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EVICT  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_INVAL  = 3'd5
  } alloc_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tag_allocator_fa_free_slot_encoder.sv
// Lowest-index-zero priority encoder over the slot valid mirror.
module free_slot_encoder #(
  parameter int N  = 128,
  parameter int BW = 7
) (
  input  logic [N-1:0]  valid_i,
  output logic          any_free_o,
  output logic [BW-1:0] index_o
);

  // Scan from the top down so the last hit written is the lowest free index.
  always_comb begin
    any_free_o = 1'b0;
    index_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        any_free_o = 1'b1;
        index_o    = BW'(i);
      end
    end
  end

endmodule

// File: rtl/tag_allocator_fa.sv
// Install/invalidate controller for the fully-associative tag table: picks a
// victim (lowest free slot, else round-robin), reads it back, then removes/writes.
module tag_allocator_fa
  import tag_allocator_fa_pkg::*;
#(
  parameter int BW_ACCESS_ADDR     = 32,
  parameter int N_WORDS_PER_BLOCK  = 16,
  parameter int N_CAPACITY_BLOCKS  = 128,
  parameter int BW_CAPACITY_BLOCKS = clog2(N_CAPACITY_BLOCKS)
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          alloc_req_i,
  input  logic [BW_ACCESS_ADDR-1:0]     alloc_addr_i,
  output logic                          alloc_ready_o,
  output logic                          alloc_done_o,
  output logic [BW_CAPACITY_BLOCKS-1:0] alloc_cache_addr_o,
  output logic                          evict_valid_o,
  output logic [BW_ACCESS_ADDR-1:0]     evict_addr_o,
  input  logic                          inval_req_i,
  input  logic [BW_CAPACITY_BLOCKS-1:0] inval_cache_addr_i,
  output logic                          inval_done_o,
  output logic [BW_CAPACITY_BLOCKS:0]   occupied_o,
  output logic                          table_wren_o,
  output logic                          table_rmen_o,
  output logic [BW_CAPACITY_BLOCKS-1:0] table_cache_addr_o,
  output logic [BW_ACCESS_ADDR-1:0]     table_access_addr_write_o,
  input  logic [BW_ACCESS_ADDR-1:0]     table_access_addr_search_i
);

  localparam int BW_WORDS_PER_BLOCK = clog2(N_WORDS_PER_BLOCK);
  localparam int BW_ACCESS_TAG      = BW_ACCESS_ADDR - BW_WORDS_PER_BLOCK;
  localparam int BW_OCC             = BW_CAPACITY_BLOCKS + 1;

  function automatic logic [BW_ACCESS_ADDR-1:0] block_align(input logic [BW_ACCESS_ADDR-1:0] a);
    return {a[BW_ACCESS_ADDR-1 -: BW_ACCESS_TAG], {BW_WORDS_PER_BLOCK{1'b0}}};
  endfunction

  alloc_state_t                  r_state;
  logic [N_CAPACITY_BLOCKS-1:0]  r_valid;
  logic [BW_CAPACITY_BLOCKS-1:0] r_rr;
  logic [BW_OCC-1:0]             r_occ;
  logic [BW_ACCESS_ADDR-1:0]     r_alloc_addr;
  logic [BW_CAPACITY_BLOCKS-1:0] r_victim;
  logic                          r_victim_valid;
  logic [BW_ACCESS_ADDR-1:0]     r_evict_addr;
  logic [BW_CAPACITY_BLOCKS-1:0] r_inval_addr;
  logic [BW_CAPACITY_BLOCKS-1:0] r_done_slot;
  logic                          r_done_evict_valid;
  logic [BW_ACCESS_ADDR-1:0]     r_done_evict_addr;

  logic                          w_any_free;
  logic [BW_CAPACITY_BLOCKS-1:0] w_free_idx;

  free_slot_encoder #(
    .N  (N_CAPACITY_BLOCKS),
    .BW (BW_CAPACITY_BLOCKS)
  ) u_free_slot_encoder (
    .valid_i    (r_valid),
    .any_free_o (w_any_free),
    .index_o    (w_free_idx)
  );

  assign alloc_cache_addr_o = r_done_slot;
  assign evict_valid_o      = r_done_evict_valid;
  assign evict_addr_o       = r_done_evict_addr;
  assign occupied_o         = r_occ;

  // Strobes decode from the state register; ready is also masked by reset.
  always_comb begin
    alloc_ready_o             = 1'b0;
    alloc_done_o              = 1'b0;
    inval_done_o              = 1'b0;
    table_wren_o              = 1'b0;
    table_rmen_o              = 1'b0;
    table_cache_addr_o        = '0;
    table_access_addr_write_o = '0;
    case (r_state)
      ST_IDLE:  alloc_ready_o = ~reset_i;
      ST_EVICT: begin
        table_cache_addr_o = r_victim;
        table_rmen_o       = r_victim_valid;
      end
      ST_WRITE: begin
        table_wren_o              = 1'b1;
        table_cache_addr_o        = r_victim;
        table_access_addr_write_o = r_alloc_addr;
      end
      ST_DONE:  alloc_done_o = 1'b1;
      ST_INVAL: begin
        table_rmen_o       = 1'b1;
        table_cache_addr_o = r_inval_addr;
        inval_done_o       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state            <= ST_IDLE;
      r_valid            <= '0;
      r_rr               <= '0;
      r_occ              <= '0;
      r_alloc_addr       <= '0;
      r_victim           <= '0;
      r_victim_valid     <= 1'b0;
      r_evict_addr       <= '0;
      r_inval_addr       <= '0;
      r_done_slot        <= '0;
      r_done_evict_valid <= 1'b0;
      r_done_evict_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inval_req_i) begin
            r_inval_addr <= inval_cache_addr_i;
            r_state      <= ST_INVAL;
          end else if (alloc_req_i) begin
            r_alloc_addr <= block_align(alloc_addr_i);
            r_state      <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          // A full table is the only case that displaces a valid block.
          r_victim       <= w_any_free ? w_free_idx : r_rr;
          r_victim_valid <= ~w_any_free;
          r_state        <= ST_EVICT;
        end
        ST_EVICT: begin
          r_evict_addr <= block_align(table_access_addr_search_i);
          r_state      <= ST_WRITE;
        end
        ST_WRITE: begin
          r_valid[r_victim] <= 1'b1;
          if (r_victim_valid) r_rr  <= r_rr + BW_CAPACITY_BLOCKS'(1);
          else                r_occ <= r_occ + BW_OCC'(1);
          r_done_slot        <= r_victim;
          r_done_evict_valid <= r_victim_valid;
          r_done_evict_addr  <= r_evict_addr;
          r_state            <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_INVAL: begin
          if (r_valid[r_inval_addr]) begin
            r_valid[r_inval_addr] <= 1'b0;
            r_occ                 <= r_occ - BW_OCC'(1);
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
